mem_arbiter: RTL and testbench

//  Shares the single-port word RAM (mem[0:DEPTH-1], based at ENTRY) between three requesters:

---
 rtl/mem_arbiter_pkg.sv | 27 ++
 rtl/mem_arbiter_pick.sv | 47 ++++
 rtl/mem_arbiter.sv | 137 +++++++++++++
 tb/tb_mem_arbiter.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared constants and types for the RAM arbiter: default geometry, FSM states
// and requester ids (bit positions of the one-hot grant vector).
package mem_arbiter_pkg;

  localparam int unsigned DEF_DEPTH = 4096;
  localparam int unsigned DEF_IDX_W = 12;
  localparam logic [31:0] DEF_ENTRY = 32'h8000_0000;
  localparam int unsigned N_REQ     = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    ID_LD = 2'd0,
    ID_D  = 2'd1,
    ID_F  = 2'd2
  } req_id_t;

  // Word offset from the RAM base; addresses below the base wrap to huge values.
  function automatic logic [31:0] word_off(input logic [31:0] addr, input logic [31:0] entry);
    return (addr - entry) >> 2;
  endfunction

endpackage

// File: rtl/mem_arbiter_pick.sv
// Three-way requester selector producing a one-hot grant. Loader always wins;
// d vs f is round-robin when MEM_ARB_RR_EN is defined, else d has fixed priority.
module arb_pick
  import mem_arbiter_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             ld_req,
  input  logic             d_req,
  input  logic             f_req,
  input  logic             advance,
  output logic [N_REQ-1:0] grant
);

`ifdef MEM_ARB_RR_EN
  logic prio_f;

  // Pointer moves to the loser of each d/f grant so held requests alternate.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prio_f <= 1'b1;
    end else if (advance) begin
      if (grant[ID_D])      prio_f <= 1'b1;
      else if (grant[ID_F]) prio_f <= 1'b0;
    end
  end

  always_comb begin
    grant = '0;
    if (ld_req)              grant[ID_LD] = 1'b1;
    else if (d_req && f_req) grant[prio_f ? ID_F : ID_D] = 1'b1;
    else if (d_req)          grant[ID_D] = 1'b1;
    else if (f_req)          grant[ID_F] = 1'b1;
  end
`else
  logic unused_rr;
  assign unused_rr = ^{clk, reset, advance};

  always_comb begin
    grant = '0;
    if (ld_req)     grant[ID_LD] = 1'b1;
    else if (d_req) grant[ID_D]  = 1'b1;
    else if (f_req) grant[ID_F]  = 1'b1;
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter for loader, CPU data and CPU fetch (IDLE->ACCESS->DONE).
// Optional round-robin d/f arbitration via the MEM_ARB_RR_EN macro.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_DEPTH,
  parameter int unsigned IDX_W = DEF_IDX_W,
  parameter logic [31:0] ENTRY = DEF_ENTRY
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ld_req,
  input  logic [31:0]      ld_addr,
  input  logic [31:0]      ld_wdata,
  output logic             ld_ready,
  input  logic             d_req,
  input  logic             d_we,
  input  logic [31:0]      d_addr,
  input  logic [31:0]      d_wdata,
  input  logic [3:0]       d_wstrb,
  output logic [31:0]      d_rdata,
  output logic             d_ready,
  input  logic             f_req,
  input  logic [31:0]      f_addr,
  output logic [31:0]      f_rdata,
  output logic             f_ready,
  output logic             mem_en,
  output logic [3:0]       mem_we,
  output logic [IDX_W-1:0] mem_idx,
  output logic [31:0]      mem_wdata,
  input  logic [31:0]      mem_rdata,
  output logic             err
);

  state_t           state;
  logic [N_REQ-1:0] grant;
  logic [N_REQ-1:0] win_q;
  logic             rd_q;
  logic             oor_q;

  logic             sel_we;
  logic [3:0]       sel_strb;
  logic [31:0]      sel_addr;
  logic [31:0]      sel_wdata;
  logic [31:0]      sel_off;
  logic             sel_ok;

  arb_pick u_pick (
    .clk     (clk),
    .reset   (reset),
    .ld_req  (ld_req),
    .d_req   (d_req),
    .f_req   (f_req),
    .advance (state == ST_IDLE),
    .grant   (grant)
  );

  always_comb begin
    sel_we    = 1'b0;
    sel_strb  = '0;
    sel_addr  = '0;
    sel_wdata = '0;
    if (grant[ID_LD]) begin
      sel_we    = 1'b1;
      sel_strb  = '1;
      sel_addr  = ld_addr;
      sel_wdata = ld_wdata;
    end else if (grant[ID_D]) begin
      sel_we    = d_we;
      sel_strb  = d_wstrb;
      sel_addr  = d_addr;
      sel_wdata = d_wdata;
    end else if (grant[ID_F]) begin
      sel_addr  = f_addr;
    end
    sel_off = word_off(sel_addr, ENTRY);
    sel_ok  = sel_off < 32'(DEPTH);
  end

  // RAM controls are registered on entry to ACCESS, so the latched request
  // fields live directly in the mem_* output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      win_q     <= '0;
      rd_q      <= 1'b0;
      oor_q     <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= '0;
      mem_idx   <= '0;
      mem_wdata <= '0;
      ld_ready  <= 1'b0;
      d_ready   <= 1'b0;
      f_ready   <= 1'b0;
      err       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (|grant) begin
            win_q     <= grant;
            rd_q      <= !sel_we;
            oor_q     <= !sel_ok;
            mem_en    <= sel_ok;
            mem_we    <= sel_ok ? (sel_strb & {4{sel_we}}) : '0;
            mem_idx   <= sel_ok ? sel_off[IDX_W-1:0] : '0;
            mem_wdata <= (sel_ok && sel_we) ? sel_wdata : '0;
            state     <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          mem_en    <= 1'b0;
          mem_we    <= '0;
          mem_idx   <= '0;
          mem_wdata <= '0;
          ld_ready  <= win_q[ID_LD];
          d_ready   <= win_q[ID_D];
          f_ready   <= win_q[ID_F];
          err       <= oor_q;
          state     <= ST_DONE;
        end
        ST_DONE: begin
          ld_ready <= 1'b0;
          d_ready  <= 1'b0;
          f_ready  <= 1'b0;
          err      <= 1'b0;
          state    <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // RAM data only arrives during DONE, so read data is steered, not registered.
  assign d_rdata = (d_ready && rd_q && !oor_q) ? mem_rdata : '0;
  assign f_rdata = (f_ready && rd_q && !oor_q) ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter with a behavioural RAM; covers both the
// fixed-priority and MEM_ARB_RR_EN builds.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        ld_req = 1'b0, d_req = 1'b0, f_req = 1'b0, d_we = 1'b0;
  logic [31:0] ld_addr = '0, ld_wdata = '0, d_addr = '0, d_wdata = '0, f_addr = '0;
  logic [3:0]  d_wstrb = '0;
  logic        ld_ready, d_ready, f_ready, mem_en, err;
  logic [31:0] d_rdata, f_rdata, mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic [3:0]  mem_we;
  logic [11:0] mem_idx;

  mem_arbiter #(.DEPTH(4096), .IDX_W(12), .ENTRY(32'h8000_0000)) dut (
    .clk(clk), .reset(reset),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_ready(ld_ready),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .f_req(f_req), .f_addr(f_addr), .f_rdata(f_rdata), .f_ready(f_ready),
    .mem_en(mem_en), .mem_we(mem_we), .mem_idx(mem_idx), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [1:0] id; logic [31:0] rdata; logic err; } sb_t;
  typedef struct packed { logic [11:0] idx; logic [3:0] we; logic [31:0] wdata; } mx_t;
  sb_t sbq[$];
  mx_t memq[$];

  int n_checks = 0;
  int n_fail = 0;
  bit ptr_f = 1'b1;
  bit prev_any = 1'b0;

  logic [31:0] ram     [0:4095];
  logic [31:0] ref_mem [0:4095];
  logic        we_a   [3];
  logic [31:0] addr_a [3];
  logic [31:0] wdata_a[3];
  logic [3:0]  strb_a [3];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] init_word(input int i);
    return (i == 0) ? 32'h0000_0093 : {16'(i), 16'hC0DE ^ 16'(i)};
  endfunction

  function automatic logic rdy(input int id);
    case (id)
      0:       return ld_ready;
      1:       return d_ready;
      default: return f_ready;
    endcase
  endfunction

  // RAM: one-cycle synchronous read, byte-enabled write
  always @(posedge clk) begin
    if (mem_en) begin
      for (int b = 0; b < 4; b++)
        if (mem_we[b]) ram[mem_idx][8*b +: 8] <= mem_wdata[8*b +: 8];
      mem_rdata <= ram[mem_idx];
    end
  end

  // Completion monitor
  always @(negedge clk) begin
    bit   any;
    sb_t  e;
    logic [1:0]  gid;
    logic [31:0] grd;
    any = ld_ready | d_ready | f_ready;
    if (any) begin
      check("ready_onehot", 32'($countones({ld_ready, d_ready, f_ready})), 32'd1);
      check("ready_pulse", {31'b0, prev_any}, 32'd0);
      check("sb_pending", {31'b0, sbq.size() != 0}, 32'd1);
      if (sbq.size() != 0) begin
        e   = sbq.pop_front();
        gid = ld_ready ? 2'd0 : (d_ready ? 2'd1 : 2'd2);
        grd = d_ready ? d_rdata : f_rdata;
        check("grant_id", {30'b0, gid}, {30'b0, e.id});
        if (e.id != 2'd0) check("rdata", grd, e.rdata);
        check("err", {31'b0, err}, {31'b0, e.err});
      end
    end else if (err) begin
      check("err_without_ready", {31'b0, any}, 32'd1);
    end
    prev_any = any;
  end

  // RAM-side monitor
  always @(negedge clk) begin
    mx_t m;
    if (mem_en) begin
      check("mem_pending", {31'b0, memq.size() != 0}, 32'd1);
      if (memq.size() != 0) begin
        m = memq.pop_front();
        check("mem_idx", {20'b0, mem_idx}, {20'b0, m.idx});
        check("mem_we", {28'b0, mem_we}, {28'b0, m.we});
        if (m.we != 4'b0) check("mem_wdata", mem_wdata, m.wdata);
      end
    end else if (mem_we != 4'b0) begin
      check("mem_we_without_en", {28'b0, mem_we}, 32'd0);
    end
  end

  function automatic int pick(input bit p_ld, input bit p_d, input bit p_f);
    if (p_ld) return 0;
`ifdef MEM_ARB_RR_EN
    if (p_d && p_f) return ptr_f ? 2 : 1;
`else
    if (p_d && p_f) return 1;
`endif
    if (p_d) return 1;
    return 2;
  endfunction

  task automatic expect_acc(input int id);
    logic [31:0] a, rd;
    logic [11:0] idx;
    logic [3:0]  strb;
    logic        we, ok;
    a    = addr_a[id];
    ok   = (a >= 32'h8000_0000) && (a < 32'h8000_4000);
    idx  = a[13:2];
    we   = (id == 0) ? 1'b1 : ((id == 1) ? we_a[1] : 1'b0);
    strb = (id == 0) ? 4'hF : strb_a[1];
    rd   = '0;
    if (ok) memq.push_back('{idx: idx, we: (we ? strb : 4'h0), wdata: (we ? wdata_a[id] : 32'h0)});
    if (ok && !we) rd = ref_mem[idx];
    if (ok && we)
      for (int b = 0; b < 4; b++)
        if (strb[b]) ref_mem[idx][8*b +: 8] = wdata_a[id][8*b +: 8];
    sbq.push_back('{id: 2'(id), rdata: rd, err: !ok});
    if (id == 1) ptr_f = 1'b1;
    if (id == 2) ptr_f = 1'b0;
  endtask

  // Hold one requester's req until it has seen `count` ready pulses.
  task automatic drv(input int id, input int count, output int lat);
    int got = 0;
    int cyc = 0;
    lat = 0;
    if (count == 0) return;
    @(posedge clk); #1;
    case (id)
      0: begin ld_addr = addr_a[0]; ld_wdata = wdata_a[0]; ld_req = 1'b1; end
      1: begin d_we = we_a[1]; d_addr = addr_a[1]; d_wdata = wdata_a[1]; d_wstrb = strb_a[1]; d_req = 1'b1; end
      default: begin f_addr = addr_a[2]; f_req = 1'b1; end
    endcase
    while (got < count) begin
      @(negedge clk);
      cyc++;
      if (rdy(id)) begin
        got++;
        if (got == 1) lat = cyc;
      end
      if (cyc > 40 * count) begin
        check("ready_timeout", 32'(got), 32'(count));
        break;
      end
    end
    @(posedge clk); #1;
    case (id)
      0:       ld_req = 1'b0;
      1:       d_req = 1'b0;
      default: f_req = 1'b0;
    endcase
  endtask

  task automatic set_stim(input int id, input logic we, input logic [31:0] a,
                          input logic [31:0] wd, input logic [3:0] st);
    we_a[id] = we; addr_a[id] = a; wdata_a[id] = wd; strb_a[id] = st;
  endtask

  task automatic single(input int id, input logic we, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] st);
    int lat;
    set_stim(id, we, a, wd, st);
    expect_acc(id);
    drv(id, 1, lat);
    check("latency", 32'(lat), 32'd3);
  endtask

  task automatic contend(input int c0, input int c1, input int c2);
    int c[3];
    int l0, l1, l2, p;
    c[0] = c0; c[1] = c1; c[2] = c2;
    while (c[0] + c[1] + c[2] > 0) begin
      p = pick(c[0] > 0, c[1] > 0, c[2] > 0);
      expect_acc(p);
      c[p]--;
    end
    fork
      drv(0, c0, l0);
      drv(1, c1, l1);
      drv(2, c2, l2);
    join
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog n_checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 4096; i++) begin
      ram[i]    <= init_word(i);
      ref_mem[i] = init_word(i);
    end
    repeat (3) @(posedge clk);
    #1;
    check("rst_flags", {26'b0, ld_ready, d_ready, f_ready, err, mem_en, |mem_we}, 32'd0);
    check("rst_mem_idx", {20'b0, mem_idx}, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_rdata", d_rdata | f_rdata, 32'd0);
    @(negedge clk) reset = 1'b1;

    // Fetch of word 0
    single(2, 1'b0, 32'h8000_0000, 32'h0, 4'h0);

    // Store aborted by reset while in ACCESS
    @(posedge clk); #1;
    d_we = 1'b1; d_addr = 32'h8000_0010; d_wdata = 32'hDEAD_BEEF; d_wstrb = 4'hF; d_req = 1'b1;
    memq.push_back('{idx: 12'd4, we: 4'hF, wdata: 32'hDEAD_BEEF});
    @(negedge clk);
    @(negedge clk);
    check("abort_in_access", {31'b0, mem_en}, 32'd1);
    #1 reset = 1'b0;
    d_req = 1'b0;
    #1;
    check("abort_flags", {26'b0, ld_ready, d_ready, f_ready, err, mem_en, |mem_we}, 32'd0);
    check("abort_mem_idx", {20'b0, mem_idx}, 32'd0);
    check("abort_mem_wdata", mem_wdata, 32'd0);
    ptr_f = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    single(1, 1'b0, 32'h8000_0010, 32'h0, 4'h0);
    single(1, 1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF);
    single(1, 1'b0, 32'h8000_0010, 32'h0, 4'h0);

    // Byte store into lane 1 of word 1
    single(1, 1'b1, 32'h8000_0005, 32'h0000_AB00, 4'b0010);
    single(1, 1'b0, 32'h8000_0004, 32'h0, 4'h0);

    // Loader write to last legal word, read back with low address bits set
    single(0, 1'b1, 32'h8000_3FFC, 32'h1234_5678, 4'h0);
    single(1, 1'b0, 32'h8000_3FFE, 32'h0, 4'h0);

    // Out of range on both sides of the window
    single(1, 1'b0, 32'h7FFF_FFFC, 32'h0, 4'h0);
    single(1, 1'b0, 32'h8000_4000, 32'h0, 4'h0);
    single(0, 1'b1, 32'h8000_4000, 32'hFFFF_FFFF, 4'h0);

    // d and f held together for four grants, then one requester drops
    single(2, 1'b0, 32'h8000_0004, 32'h0, 4'h0);
    set_stim(1, 1'b0, 32'h8000_0008, 32'h0, 4'h0);
    set_stim(2, 1'b0, 32'h8000_000C, 32'h0, 4'h0);
`ifdef MEM_ARB_RR_EN
    contend(0, 3, 2);
`else
    contend(0, 4, 1);
`endif

    // All three at once: loader first, f reads what the loader wrote
    set_stim(0, 1'b1, 32'h8000_0020, 32'hCAFE_F00D, 4'h0);
    set_stim(1, 1'b1, 32'h8000_0024, 32'h55AA_0000, 4'b1100);
    set_stim(2, 1'b0, 32'h8000_0020, 32'h0, 4'h0);
    contend(1, 1, 1);
    single(1, 1'b0, 32'h8000_0024, 32'h0, 4'h0);

    repeat (4) @(posedge clk);
    check("sb_drained", 32'(sbq.size()), 32'd0);
    check("memq_drained", 32'(memq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
